// File: rtl/debug_trigger_pkg.sv
// Shared constants for the debug capture path: trace depth and FSM encodings.
// Build option: DEBUG_DEDUP_EN (see debug_trigger).
package debug_trigger_pkg;
    localparam int DEBUG_SIZE = 1024;

    localparam logic [1:0] DTRG_IDLE    = 2'd0;
    localparam logic [1:0] DTRG_ARMED   = 2'd1;
    localparam logic [1:0] DTRG_CAPTURE = 2'd2;
    localparam logic [1:0] DTRG_DONE    = 2'd3;
endpackage

// File: rtl/debug_trigger.sv
// Trace capture control: arm, wait for PC trigger, emit one record per commit, stop after CAPTURE_LEN or halt.
// Latency: commit at N -> debug_we/debug_data at N+1; no backpressure. DEBUG_DEDUP_EN drops repeats of the last recorded PC.
module debug_trigger
    import debug_trigger_pkg::*;
#(
    parameter int CAPTURE_LEN = DEBUG_SIZE - 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        w_arm,
    input  logic        w_halt,
    input  logic        w_trig_en,
    input  logic [31:0] w_trig_pc,
    input  logic        w_commit,
    input  logic [31:0] w_pc,
    output logic        debug_we,
    output logic [31:0] debug_data,
    output logic        w_stop,
    output logic [1:0]  w_state
);
    localparam int              CW    = $clog2(CAPTURE_LEN + 1);
    localparam logic [CW-1:0]   LEN_C = CW'(CAPTURE_LEN);
    localparam logic [CW-1:0]   ONE_C = CW'(1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] count_nxt;
    logic          rec;
    logic          trig_hit;
    logic          dup;

    assign trig_hit = !w_trig_en || (w_pc == w_trig_pc);

`ifdef DEBUG_DEDUP_EN
    logic [31:0] last_pc;
    logic        last_vld;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_pc  <= 32'd0;
            last_vld <= 1'b0;
        end else if (rec) begin
            last_pc  <= w_pc;
            last_vld <= 1'b1;
        end
    end

    assign dup = last_vld && (w_pc == last_pc);
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = r_count;
        rec       = 1'b0;
        case (state)
            DTRG_IDLE: begin
                if (w_arm)
                    state_nxt = DTRG_ARMED;
            end
            DTRG_ARMED: begin
                // The trigger commit is record #1; a coincident halt still keeps it.
                if (w_commit && trig_hit) begin
                    rec       = 1'b1;
                    count_nxt = ONE_C;
                    state_nxt = (LEN_C == ONE_C || w_halt) ? DTRG_DONE : DTRG_CAPTURE;
                end else if (w_halt) begin
                    state_nxt = DTRG_DONE;
                end
            end
            DTRG_CAPTURE: begin
                if (w_commit && !dup) begin
                    rec       = 1'b1;
                    count_nxt = r_count + ONE_C;
                end
                if (w_halt || (rec && count_nxt == LEN_C))
                    state_nxt = DTRG_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= DTRG_IDLE;
            r_count    <= '0;
            debug_we   <= 1'b0;
            debug_data <= 32'd0;
            w_stop     <= 1'b0;
        end else begin
            state    <= state_nxt;
            r_count  <= count_nxt;
            debug_we <= rec;
            if (rec)
                debug_data <= w_pc;
            // Registered alongside the final strobe so the buffer keeps that record before dumping.
            if (state_nxt == DTRG_DONE)
                w_stop <= 1'b1;
        end
    end

    assign w_state = state;
endmodule

// File: tb/tb_debug_trigger.sv
// Self-checking bench: two instances (CAPTURE_LEN 4 and 8) against a behavioural model, directed plan plus random traffic.
module tb_debug_trigger;
    import debug_trigger_pkg::*;

`ifdef DEBUG_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        w_arm, w_halt, w_trig_en, w_commit;
    logic [31:0] w_trig_pc, w_pc;

    logic        dwe  [2];
    logic [31:0] ddat [2];
    logic        dstop[2];
    logic [1:0]  dst  [2];

    always #5 CLK = ~CLK;

    debug_trigger #(.CAPTURE_LEN(4)) dut0 (
        .CLK(CLK), .RST(RST), .w_arm(w_arm), .w_halt(w_halt), .w_trig_en(w_trig_en),
        .w_trig_pc(w_trig_pc), .w_commit(w_commit), .w_pc(w_pc),
        .debug_we(dwe[0]), .debug_data(ddat[0]), .w_stop(dstop[0]), .w_state(dst[0])
    );
    debug_trigger #(.CAPTURE_LEN(8)) dut1 (
        .CLK(CLK), .RST(RST), .w_arm(w_arm), .w_halt(w_halt), .w_trig_en(w_trig_en),
        .w_trig_pc(w_trig_pc), .w_commit(w_commit), .w_pc(w_pc),
        .debug_we(dwe[1]), .debug_data(ddat[1]), .w_stop(dstop[1]), .w_state(dst[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 waiting for trigger, 2 recording, 3 finished.
    int          LEN[2] = '{4, 8};
    int          ph [2];
    int          n  [2];
    logic [31:0] last[2];
    bit          have_last[2];
    bit          hit;
    bit          mvalid = 1'b0;
    logic        ew [2];
    logic [31:0] ed [2];

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                ph[i] = 0; n[i] = 0; last[i] = 0; have_last[i] = 0;
                ew[i] = 0; ed[i] = 0;
            end else begin
                ew[i] = 0;
                if (ph[i] == 0) begin
                    if (w_arm) ph[i] = 1;
                end else if (ph[i] != 3) begin
                    if (ph[i] == 1)
                        hit = w_commit && (!w_trig_en || w_pc == w_trig_pc);
                    else
                        hit = w_commit && !(DEDUP && have_last[i] && w_pc == last[i]);
                    if (hit) begin
                        n[i]++;
                        ew[i] = 1; ed[i] = w_pc;
                        last[i] = w_pc; have_last[i] = 1;
                        ph[i] = 2;
                    end
                    if (w_halt || (hit && n[i] == LEN[i])) ph[i] = 3;
                end
            end
        end
        if (RST) mvalid = 1'b1;
    end

    logic [31:0] got0[$];
    logic [31:0] got1[$];

    always @(posedge CLK) begin
        #1;
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("we[%0d]", i), 32'(dwe[i]), 32'(ew[i]));
                chk($sformatf("data[%0d]", i), ddat[i], ed[i]);
                chk($sformatf("stop[%0d]", i), 32'(dstop[i]), 32'(ph[i] == 3));
                chk($sformatf("state[%0d]", i), 32'(dst[i]), 32'(ph[i]));
            end
        end
        if (dwe[0]) got0.push_back(ddat[0]);
        if (dwe[1]) got1.push_back(ddat[1]);
    end

    task automatic step(input logic a, input logic h, input logic c, input logic [31:0] pc);
        w_arm = a; w_halt = h; w_commit = c; w_pc = pc;
        @(negedge CLK);
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset(input int k);
        RST = 1'b1;
        idle(k);
        RST = 1'b0;
        got0.delete();
        got1.delete();
    endtask

    task automatic chk_got(input string nm, input int inst, input logic [31:0] e[$]);
        logic [31:0] g[$];
        g = (inst == 0) ? got0 : got1;
        chk($sformatf("%s[%0d].count", nm, inst), 32'(g.size()), 32'(e.size()));
        for (int k = 0; k < e.size() && k < g.size(); k++)
            chk($sformatf("%s[%0d].rec%0d", nm, inst, k), g[k], e[k]);
    endtask

    task automatic chk_end(input string nm, input int inst, input logic s, input logic [1:0] st);
        chk({nm, ".stop"}, 32'(dstop[inst]), 32'(s));
        chk({nm, ".state"}, 32'(dst[inst]), 32'(st));
    endtask

    logic [31:0] exq[$];
    logic [31:0] pool[4];
    logic [31:0] base;

    initial begin
        RST = 1'b1; w_arm = 0; w_halt = 0; w_trig_en = 0; w_trig_pc = 0; w_commit = 0; w_pc = 0;
        @(negedge CLK);

        // Reset, then commits with no arm
        do_reset(2);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1, 32'h40 + 32'(4 * k));
        exq.delete();
        chk_got("noarm", 0, exq);
        chk_end("noarm0", 0, 1'b0, DTRG_IDLE);

        // PC trigger; commit coincident with arm is ignored even though it matches
        do_reset(2);
        w_trig_en = 1'b1; w_trig_pc = 32'h100;
        step(1'b1, 1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 1'b1, 32'hF8);
        step(1'b0, 1'b0, 1'b1, 32'hFC);
        step(1'b0, 1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 1'b1, 32'h104);
        idle(2);
        exq = {32'h100, 32'h104};
        chk_got("pctrig", 0, exq);
        chk_got("pctrig", 1, exq);
        chk_end("pctrig0", 0, 1'b0, DTRG_CAPTURE);

        // Length limit
        do_reset(1);
        w_trig_en = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1, 32'h10 + 32'(4 * k));
        idle(2);
        exq = {32'h10, 32'h14, 32'h18, 32'h1C};
        chk_got("len", 0, exq);
        chk_end("len0", 0, 1'b1, DTRG_DONE);
        chk_end("len1", 1, 1'b0, DTRG_CAPTURE);

        // Halt together with a commit in CAPTURE
        do_reset(1);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h1F0);
        step(1'b0, 1'b1, 1'b1, 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'h204);
        step(1'b1, 1'b0, 1'b1, 32'h208);
        idle(1);
        exq = {32'h1F0, 32'h200};
        chk_got("haltcap", 0, exq);
        chk_end("haltcap1", 1, 1'b1, DTRG_DONE);

        // Halt while ARMED
        do_reset(1);
        w_trig_en = 1'b1; w_trig_pc = 32'hDEAD;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h10);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'hDEAD);
        idle(1);
        exq.delete();
        chk_got("haltarm", 0, exq);
        chk_end("haltarm0", 0, 1'b1, DTRG_DONE);

        // Spin-loop deduplication
        do_reset(1);
        w_trig_en = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h300);
        step(1'b0, 1'b0, 1'b1, 32'h304);
        step(1'b0, 1'b0, 1'b1, 32'h304);
        step(1'b0, 1'b0, 1'b1, 32'h304);
        step(1'b0, 1'b0, 1'b1, 32'h308);
        idle(1);
        if (DEDUP) exq = {32'h300, 32'h304, 32'h308};
        else       exq = {32'h300, 32'h304, 32'h304, 32'h304, 32'h308};
        chk_got("dedup", 1, exq);
        chk("dedup.r_count", 32'(dut1.r_count), DEDUP ? 32'd3 : 32'd5);

        // Reset mid-capture, then re-arm
        do_reset(1);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h400);
        step(1'b0, 1'b0, 1'b1, 32'h404);
        RST = 1'b1;
        step(1'b0, 1'b0, 1'b1, 32'h408);
        RST = 1'b0;
        chk("midrst.we", 32'(dwe[0]), 32'd0);
        chk_end("midrst0", 0, 1'b0, DTRG_IDLE);
        got0.delete(); got1.delete();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h500);
        idle(1);
        exq = {32'h500};
        chk_got("rearm", 0, exq);
        chk("rearm.r_count", 32'(dut0.r_count), 32'd1);

        // Random traffic with a small PC pool so triggers and repeats are frequent
        for (int r = 0; r < 16; r++) begin
            do_reset(1);
            base = 32'h1000 + 32'($urandom_range(0, 15) * 16);
            for (int k = 0; k < 4; k++) pool[k] = base + 32'(4 * k);
            w_trig_en = 1'($urandom_range(0, 1));
            w_trig_pc = pool[$urandom_range(0, 3)];
            for (int k = 0; k < 150; k++) begin
                RST = ($urandom_range(0, 199) == 0);
                step(($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 3) != 0), pool[$urandom_range(0, 3)]);
            end
            RST = 1'b0;
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
